div_restoring_seq: RTL and testbench
====================================

Name: div_restoring_seq

Overview:
- Parametrised sequential restoring divider; successor to the fixed 16-bit quotient shift register.
- Integrates the A:Q shift pair, the divisor register, a trial subtractor, an iteration counter and a start/done handshake.
- Produces an unsigned quotient and remainder at one quotient bit per clock.
- Sits between the operand registers and the result bus of the arithmetic unit.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits; legal range is 2 to 64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserts when 0).
- start  input  1  request a division; sampled on a rising clk edge.
- dividend  input  WIDTH  unsigned dividend; sampled only when start is accepted.
- divisor  input  WIDTH  unsigned divisor; sampled only when start is accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  set with done when the divisor was 0; held until the next accepted start.
- quotient  output  WIDTH  result quotient; held until the next completion.
- remainder  output  WIDTH  result remainder; held until the next completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE; A, Q, M and the counter clear.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Reset asserted mid-operation aborts the division; no done is produced.
- States are IDLE, RUN and DONE. All registers update on the rising clk edge only.
- Start acceptance:
  - start is accepted in IDLE or DONE, which allows back-to-back operations. It is ignored in RUN.
  - On acceptance: Q<=dividend, M<=divisor, A (WIDTH+1 bits)<=0, cnt<=WIDTH, div_by_zero<=0.
  - If divisor!=0: go to RUN (busy=1 in the following cycle).
  - If divisor==0: go directly to DONE. quotient<={WIDTH{1}}, remainder<=dividend, div_by_zero<=1. done is high 1 cycle after acceptance.
- RUN, each cycle:
  - S = {A[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - D = S - {1'b0, M} (WIDTH+1 bits, two's complement).
  - If D[WIDTH]==1 (negative, restore): A<=S, Q<={Q[WIDTH-2:0], 1'b0}.
  - Otherwise: A<=D, Q<={Q[WIDTH-2:0], 1'b1}. The inserted bit is always ~D[WIDTH].
  - cnt<=cnt-1.
  - When cnt==1 in RUN: the next state is DONE. quotient<=next Q, remainder<=next A[WIDTH-1:0].
- Latency: exactly WIDTH RUN cycles. done is high in the cycle WIDTH+1 clocks after the start edge. busy is high for exactly WIDTH cycles.
- DONE:
  - Lasts exactly 1 cycle with done=1 and busy=0.
  - Next state is RUN (if start with divisor!=0), DONE (if start with divisor 0), otherwise IDLE.
- Output holding:
  - quotient, remainder and div_by_zero hold their last values through IDLE and RUN until overwritten at the next completion.
  - Exception: div_by_zero clears on start acceptance.
- Arithmetic: unsigned only; no overflow is possible for a nonzero divisor. A[WIDTH] is 0 at every step after the restore or subtract.
- Input stability: dividend and divisor are don't-care outside the acceptance edge.

Test Plan:
- WIDTH=16, start with dividend=100, divisor=7 -> busy for 16 cycles; done at cycle 17 with quotient=14, remainder=2, div_by_zero=0.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; then dividend=3, divisor=10 -> quotient=0, remainder=3.
- divisor=0, dividend=5 -> done 1 cycle after start; quotient=16'hFFFF, remainder=5, div_by_zero=1. The next valid start clears div_by_zero.
- Start 1000/3, pulse start again with 50/5 at cycle 6 -> second start ignored; completion gives 333 r 1. Start asserted in the DONE cycle -> new op accepted, busy the next cycle.
- Start 1000/3, drive rst=0 at cycle 8 between edges -> all outputs 0 immediately (asynchronous), no done. After release, 42/6 -> 7 r 0.
- WIDTH=8 and WIDTH=32 instances, randomised operands (2000 each) -> quotient*divisor+remainder==dividend and remainder<divisor; done latency == WIDTH+1.

Source files
------------

// File: rtl/div_restoring_seq.sv
// rtl/div_restoring_seq.sv - parametrised sequential restoring divider, one quotient bit per clock
//
// Purpose:
//   Unsigned WIDTH-bit division using the classic restoring algorithm on an
//   A:Q shift pair. A start in IDLE or DONE loads the operands. WIDTH trial
//   subtractions follow, then a one-cycle done pulse. A zero divisor skips
//   the iteration and completes on the next cycle with div_by_zero set.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   start        request a division (accepted in IDLE or DONE, ignored in RUN)
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse when quotient/remainder become valid
//   div_by_zero  set with done for a zero divisor, cleared on the next accepted start
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion

module div_restoring_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  // The partial remainder's top bit is always 0 after a restore or a
  // subtract, so only the low WIDTH bits of A are stored.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  // Shift the next dividend bit into A, then trial-subtract the divisor.
  assign shifted = {a_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          q_d   = dividend;
          m_d   = divisor;
          a_d   = '0;
          cnt_d = CNT_W'(WIDTH);
          dbz_d = 1'b0;
          if (divisor != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end

      S_RUN: begin
        // A negative trial result restores the shifted value; the inserted
        // quotient bit is the inverse of the trial sign.
        if (trial[WIDTH]) begin
          a_d = shifted[WIDTH-1:0];
        end else begin
          a_d = trial[WIDTH-1:0];
        end
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = a_d;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// tb/tb_div_restoring_seq.sv - self-checking bench for div_restoring_seq at WIDTH 8, 16 and 32
//
// Purpose:
//   Directed scenarios on a 16-bit instance plus randomised operands on
//   8-bit and 32-bit instances, each checked against plain integer division.
//
// Ports: none (top-level bench).

module tb_div_restoring_seq;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic        s8_st,  s16_st,  s32_st;
  logic [7:0]  s8_dd,  s8_dv,  s8_q,  s8_r;
  logic [15:0] s16_dd, s16_dv, s16_q, s16_r;
  logic [31:0] s32_dd, s32_dv, s32_q, s32_r;
  logic        s8_busy,  s8_done,  s8_dz;
  logic        s16_busy, s16_done, s16_dz;
  logic        s32_busy, s32_done, s32_dz;

  div_restoring_seq #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(s8_st), .dividend(s8_dd), .divisor(s8_dv),
    .busy(s8_busy), .done(s8_done), .div_by_zero(s8_dz),
    .quotient(s8_q), .remainder(s8_r)
  );

  div_restoring_seq #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .start(s16_st), .dividend(s16_dd), .divisor(s16_dv),
    .busy(s16_busy), .done(s16_done), .div_by_zero(s16_dz),
    .quotient(s16_q), .remainder(s16_r)
  );

  div_restoring_seq #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start(s32_st), .dividend(s32_dd), .divisor(s32_dv),
    .busy(s32_busy), .done(s32_done), .div_by_zero(s32_dz),
    .quotient(s32_q), .remainder(s32_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [63:0] dd, input logic [63:0] dv, input logic st);
    case (w)
      8:       begin s8_dd  = dd[7:0];  s8_dv  = dv[7:0];  s8_st  = st; end
      16:      begin s16_dd = dd[15:0]; s16_dv = dv[15:0]; s16_st = st; end
      default: begin s32_dd = dd[31:0]; s32_dv = dv[31:0]; s32_st = st; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      8:       return s8_busy;
      16:      return s16_busy;
      default: return s32_busy;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      8:       return s8_done;
      16:      return s16_done;
      default: return s32_done;
    endcase
  endfunction

  function automatic logic get_dz(input int w);
    case (w)
      8:       return s8_dz;
      16:      return s16_dz;
      default: return s32_dz;
    endcase
  endfunction

  function automatic logic [63:0] get_q(input int w);
    case (w)
      8:       return 64'(s8_q);
      16:      return 64'(s16_q);
      default: return 64'(s32_q);
    endcase
  endfunction

  function automatic logic [63:0] get_r(input int w);
    case (w)
      8:       return 64'(s8_r);
      16:      return 64'(s16_r);
      default: return 64'(s32_r);
    endcase
  endfunction

  // One complete operation: request, track busy/done edge by edge, then
  // compare against integer division. Edge 1 is the accepting edge.
  task automatic do_op(input int w, input logic [63:0] dd_in, input logic [63:0] dv_in,
                       input string tag);
    logic [63:0] mask, dd, dv, exp_q, exp_r;
    logic        exp_z, first_busy, first_dz;
    int          lat, busy_cnt;
    mask = (64'd1 << w) - 64'd1;
    dd   = dd_in & mask;
    dv   = dv_in & mask;
    if (dv == 64'd0) begin
      exp_q = mask;
      exp_r = dd;
      exp_z = 1'b1;
    end else begin
      exp_q = dd / dv;
      exp_r = dd % dv;
      exp_z = 1'b0;
    end
    drive(w, dd, dv, 1'b1);
    lat        = -1;
    busy_cnt   = 0;
    first_busy = 1'b0;
    first_dz   = 1'b0;
    for (int e = 1; e <= w + 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        drive(w, dd, dv, 1'b0);
        first_busy = get_busy(w);
        first_dz   = get_dz(w);
      end
      if (get_busy(w)) busy_cnt++;
      if (get_done(w)) begin
        lat = e;
        break;
      end
    end
    chk({tag, " latency"},    64'(lat),        (dv == 64'd0) ? 64'd1 : 64'(w + 1));
    chk({tag, " busy_cnt"},   64'(busy_cnt),   (dv == 64'd0) ? 64'd0 : 64'(w));
    chk({tag, " busy_next"},  64'(first_busy), 64'(!exp_z));
    chk({tag, " dz_accept"},  64'(first_dz),   64'(exp_z));
    chk({tag, " quotient"},   get_q(w),        exp_q);
    chk({tag, " remainder"},  get_r(w),        exp_r);
    chk({tag, " div_by_0"},   64'(get_dz(w)),  64'(exp_z));
  endtask

  task automatic rand_ops(input int w, input int n);
    logic [63:0] mask, dd, dv;
    int          sel;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      dd  = {$urandom, $urandom} & mask;
      sel = int'($urandom_range(0, 63));
      if (sel == 0)      dv = 64'd0;
      else if (sel < 20) dv = 64'($urandom_range(1, 15));
      else               dv = {$urandom, $urandom} & mask;
      do_op(w, dd, dv, $sformatf("rand%0d", w));
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    rst = 1'b0;
    drive(8, 64'd0, 64'd0, 1'b0);
    drive(16, 64'd0, 64'd0, 1'b0);
    drive(32, 64'd0, 64'd0, 1'b0);
    #1;
    chk("reset busy",      64'(s16_busy), 64'd0);
    chk("reset done",      64'(s16_done), 64'd0);
    chk("reset dz",        64'(s16_dz),   64'd0);
    chk("reset quotient",  64'(s16_q),    64'd0);
    chk("reset remainder", 64'(s16_r),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op(16, 64'd100, 64'd7, "d100_7");
    @(posedge clk);
    #1;
    chk("done_pulse_end",  64'(s16_done), 64'd0);
    chk("idle_busy",       64'(s16_busy), 64'd0);
    chk("hold_quotient",   64'(s16_q),    64'd14);
    chk("hold_remainder",  64'(s16_r),    64'd2);

    @(negedge clk);
    do_op(16, 64'hFFFF, 64'd1, "dFFFF_1");
    do_op(16, 64'd3, 64'd10, "d3_10");
    do_op(16, 64'd5, 64'd0, "d5_0");
    do_op(16, 64'd100, 64'd7, "after_dz");

    // A second start while iterating must be ignored.
    @(negedge clk);
    s16_dd = 16'd1000;
    s16_dv = 16'd3;
    s16_st = 1'b1;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) s16_st = 1'b0;
      if (e == 5) begin
        s16_dd = 16'd50;
        s16_dv = 16'd5;
        s16_st = 1'b1;
      end
      if (e == 6) s16_st = 1'b0;
      if (s16_done) begin
        lat = e;
        break;
      end
    end
    chk("ignore latency",   64'(lat),   64'd17);
    chk("ignore quotient",  64'(s16_q), 64'd333);
    chk("ignore remainder", 64'(s16_r), 64'd1);
    // Start presented during the DONE cycle.
    do_op(16, 64'd200, 64'd7, "b2b_done");

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    s16_dd = 16'd1000;
    s16_dv = 16'd3;
    s16_st = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) s16_st = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort busy",      64'(s16_busy), 64'd0);
    chk("abort done",      64'(s16_done), 64'd0);
    chk("abort dz",        64'(s16_dz),   64'd0);
    chk("abort quotient",  64'(s16_q),    64'd0);
    chk("abort remainder", 64'(s16_r),    64'd0);
    done_seen = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (s16_done) done_seen++;
    end
    chk("abort no_done", 64'(done_seen), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(16, 64'd42, 64'd6, "d42_6");

    @(negedge clk);
    fork
      rand_ops(8, 2000);
      rand_ops(32, 2000);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
